// File: rtl/dir_rom_arbiter_if.sv
// Request/ROM/response bundle for the shared direction-ROM arbiter.
// master = requester/ROM environment side, slave = arbiter side.
interface dir_rom_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 8,
  parameter int DW    = 5
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0][AW-1:0] req_addr;   // lane i sits at bits [i*AW +: AW]
  logic [AW-1:0]            rom_a;
  logic [DW-1:0]            rom_spo;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DW-1:0]            rsp_data;
  logic [IW-1:0]            rsp_id;

  modport master (
    output req_valid, req_addr, rom_spo, rsp_ready,
    input  req_ready, rom_a, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_addr, rom_spo, rsp_ready,
    output req_ready, rom_a, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/dir_rom_arbiter.sv
// Round-robin arbiter sharing one combinational 256x5 direction ROM among
// N_REQ descriptor-bin requesters; one registered, ID-tagged response slot.

// Per-lane rotated priority: distance of this lane from the round-robin pointer.
module dir_rom_arb_lane #(
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic [IW-1:0] i_ptr,
  input  logic          i_valid,
  output logic          o_elig,
  output logic [IW-1:0] o_dist
);
  assign o_elig = i_valid;
  // N_REQ is a power of two, so the IW-bit subtraction wraps modulo N_REQ.
  assign o_dist = IW'(LANE) - i_ptr;
endmodule

module dir_rom_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 8,
  parameter int DW    = 5,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  dir_rom_arbiter_if.slave bus
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                   r_state, w_state_nxt;
  logic [IW-1:0]            r_ptr;
  logic [DW-1:0]            r_data;
  logic [IW-1:0]            r_id;

  logic [N_REQ-1:0]         w_elig;
  logic [N_REQ-1:0][IW-1:0] w_dist;
  logic                     w_any;
  logic [IW-1:0]            w_win;
  logic [IW-1:0]            w_best;
  logic                     w_can_issue;
  logic                     w_grant;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_lane
      dir_rom_arb_lane #(.IW(IW), .LANE(g)) u_lane (
        .i_ptr   (r_ptr),
        .i_valid (bus.req_valid[g]),
        .o_elig  (w_elig[g]),
        .o_dist  (w_dist[g])
      );
    end
  endgenerate

  // Winner = eligible lane nearest the pointer; distances are unique.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_best = '1;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_elig[i] && (!w_any || (w_dist[i] < w_best))) begin
        w_any  = 1'b1;
        w_best = w_dist[i];
        w_win  = IW'(i);
      end
    end
  end

  assign w_can_issue   = (r_state == S_EMPTY) || bus.rsp_ready;
  assign w_grant       = w_can_issue && w_any;
  assign bus.rom_a     = w_any ? bus.req_addr[w_win] : '0;
  assign bus.req_ready = w_grant ? (N_REQ'(1) << w_win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // A grant always refills the slot, even when it pops in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_grant) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_grant)            w_state_nxt = S_FULL;
        else if (bus.rsp_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Data and ID hold across pops; only a grant reloads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_data <= '0;
      r_id   <= '0;
    end else if (w_grant) begin
      r_ptr  <= w_win + IW'(1);
      r_data <= bus.rom_spo;
      r_id   <= w_win;
    end
  end

  assign bus.rsp_valid = (r_state == S_FULL);
  assign bus.rsp_data  = r_data;
  assign bus.rsp_id    = r_id;

endmodule

// File: tb/tb_dir_rom_arbiter.sv
// Directed bench for dir_rom_arbiter: behavioural ROM, scoreboard of expected
// responses pushed at grant time and popped when the response register loads.
module tb_dir_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 5;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dir_rom_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  dir_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    case (a)
      8'h00:   return 5'h05;
      8'h30:   return 5'h06;
      8'hFF:   return 5'h1C;
      8'h80:   return 5'h08;
      8'h06:   return 5'h1F;
      default: return a[4:0] ^ a[7:3];
    endcase
  endfunction

  always_comb bus.rom_spo = rom_f(bus.rom_a);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t   sb[$];
  rsp_t   last;
  logic   exp_vld;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rom_a",     32'(bus.rom_a),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    exp_vld = 1'b0;
    last = '0;
  endtask

  // Called at posedge+1; drives one cycle and checks both the combinational
  // grant and the registered result after the next edge.
  task automatic step(input logic [N-1:0] v, input logic rr, input logic [N-1:0] exp_rdy);
    int   idx;
    rsp_t e;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (exp_rdy != '0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (exp_rdy[i]) idx = i;
      chk("rom_a", 32'(bus.rom_a), 32'(bus.req_addr[idx]));
      e.id   = IW'(idx);
      e.data = rom_f(bus.req_addr[idx]);
      sb.push_back(e);
    end else if (v == '0) begin
      chk("rom_a_idle", 32'(bus.rom_a), 32'd0);
    end
    @(posedge clk); #1;
    if (exp_rdy != '0) begin
      last    = sb.pop_front();
      exp_vld = 1'b1;
    end else begin
      exp_vld = exp_vld && !rr;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_vld));
    chk("rsp_data",  32'(bus.rsp_data),  32'(last.data));
    chk("rsp_id",    32'(bus.rsp_id),    32'(last.id));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b1;
    exp_vld = 1'b0;
    last = '0;
    #2;

    // single request, one-cycle latency
    do_reset();
    bus.req_addr[0] = 8'h00;
    step(4'b0001, 1'b1, 4'b0001);

    // all four valid: one grant per cycle, in order 0..3
    do_reset();
    bus.req_addr[0] = 8'h30; bus.req_addr[1] = 8'hFF;
    bus.req_addr[2] = 8'h80; bus.req_addr[3] = 8'h06;
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b1110, 1'b1, 4'b0010);
    step(4'b1100, 1'b1, 4'b0100);
    step(4'b1000, 1'b1, 4'b1000);

    // backpressure while FULL, then grant on the cycle rsp_ready rises
    bus.req_addr[0] = 8'h11; bus.req_addr[1] = 8'h22;
    step(4'b0011, 1'b0, 4'b0000);
    step(4'b0011, 1'b0, 4'b0000);
    step(4'b0011, 1'b0, 4'b0000);
    step(4'b0011, 1'b1, 4'b0001);
    step(4'b0010, 1'b1, 4'b0010);

    // rotation: grant 3 (ptr->0), lone 2 (ptr->3), then 3 beats 0
    bus.req_addr[3] = 8'h40;
    step(4'b1000, 1'b1, 4'b1000);
    bus.req_addr[2] = 8'h55;
    step(4'b0100, 1'b1, 4'b0100);
    bus.req_addr[3] = 8'h66; bus.req_addr[0] = 8'h77;
    step(4'b1001, 1'b1, 4'b1000);
    step(4'b0001, 1'b1, 4'b0001);

    // pop with nothing pending, idle cycle must not rotate ptr (stays 1)
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    bus.req_addr[0] = 8'h01; bus.req_addr[1] = 8'h02;
    bus.req_addr[2] = 8'h03; bus.req_addr[3] = 8'h04;
    step(4'b1111, 1'b1, 4'b0010);
    step(4'b1101, 1'b1, 4'b0100);

    // asynchronous reset while FULL with requests in flight
    bus.req_valid = 4'b1011;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("async_rsp_id",    32'(bus.rsp_id),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    exp_vld = 1'b0;
    last = '0;
    step(4'b1011, 1'b1, 4'b0001);
    step(4'b1010, 1'b1, 4'b0010);
    step(4'b1000, 1'b1, 4'b1000);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dir_rom_arbiter.md
# dir_rom_arbiter

Round-robin arbiter that shares one combinational 256x5 orientation-direction ROM among several descriptor-bin requesters in the SIFT descriptor stage. Each requester presents an 8-bit lookup address with a valid/ready handshake. The arbiter drives the ROM address, registers the 5-bit two's-complement result, and returns it tagged with the requester index over a single valid/ready response port.

## Interface
- N_REQ, 4: number of requesters; power of two, 2..8.
- AW, 8: ROM address width.
- DW, 5: ROM data width (two's complement bin offset).
- IW, $clog2(N_REQ): requester-ID width (derived).

- clk  in  1  rising-edge clock; the block uses this single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  N_REQ  bit i: requester i has a lookup pending.
- req_addr  in  N_REQ*AW  requester i address in bits [i*AW +: AW].
- req_ready  out  N_REQ  bit i: requester i's lookup accepted this cycle (one-hot or zero).
- rom_a  out  AW  address to the ROM (combinational).
- rom_spo  in  DW  ROM data for rom_a (combinational, same cycle).
- rsp_valid  out  1  response register holds a result.
- rsp_data  out  DW  registered ROM result, passed raw (no sign extension).
- rsp_id  out  IW  index of the requester that issued the response.
- rsp_ready  in  1  downstream accepts the response.

## Operation
- Output register state: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_issue = !rsp_valid || rsp_ready.
- Winner: the first i with req_valid[i], scanning ptr, ptr+1, ... mod N_REQ.
- rom_a = req_addr of the winner. With no valid request, rom_a = 0.
- Grant: req_ready[winner] = can_issue && any req_valid. All other req_ready bits are 0. req_ready is combinational from req_valid, ptr, rsp_valid and rsp_ready.
- On grant:
  - rsp_data <= rom_spo, rsp_id <= winner, rsp_valid <= 1.
  - ptr <= (winner+1) mod N_REQ.
- No grant and rsp_ready while FULL: rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- No grant while FULL and !rsp_ready: everything holds (backpressure). req_ready is all 0.
- Pop and grant in the same cycle: the new result replaces the old one and rsp_valid stays 1. This gives one lookup per cycle, sustained.
- ptr changes only on a grant, so an idle cycle does not rotate priority.
- A requester must hold req_valid and req_addr stable until its req_ready. The block does not check this.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,N_REQ-1,0,...
- Requesters may raise and drop req_valid freely. There is no lock and no starvation beyond N_REQ-1 grants.

## Timing
- Reset values (asynchronous assert, synchronous deassert at the rst_n edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0.
  - req_ready=0 and rom_a=0 while req_valid=0.
- Latency: a grant at edge k gives rsp_valid=1 with that data after edge k. That is one cycle from acceptance to response.
- Throughput: 1 lookup per cycle while rsp_ready=1.
- Reset mid-operation: a pending response is dropped, and in-flight requests stay valid and are re-arbitrated from ptr=0 after release.
- Combinational path: req_valid -> winner -> rom_a -> ROM -> rsp_data D input. The ROM is a LUT, and this path must meet the descriptor-stage clock.

## Test plan
- Reset, then req_valid=4'b0001, req_addr[0]=8'h00 -> req_ready=4'b0001 the same cycle; the next cycle gives rsp_valid=1, rsp_data=5'h05, rsp_id=0.
- All four valid with addresses 8'h30, 8'hFF, 8'h80, 8'h06, rsp_ready=1 -> responses on 4 consecutive cycles: (id0, 5'h06), (id1, 5'h1C), (id2, 5'h08), (id3, 5'h1F).
- rsp_ready=0 for 3 cycles while FULL with requests pending -> req_ready=0, and rsp_data/rsp_id hold. When rsp_ready rises, a new grant occurs in that cycle.
- Only requester 2 valid after a grant to 3 (ptr=0) -> requester 2 is granted and ptr becomes 3. Then requesters 3 and 0 are both valid -> requester 3 is granted first.
- Pop with no request -> rsp_valid falls the next cycle, and rsp_data keeps its value. An idle cycle leaves ptr unchanged.
- Assert rst_n=0 asynchronously while FULL -> rsp_valid=0 immediately, without a clock edge. After release, requests are granted starting from requester 0.
